// File: rtl/toggle_event_receiver.sv
// ---------------------------------------------------------------------------
// toggle_event_receiver
//
// Receiving end of a toggle-encoded event link. The remote sender flips its
// output once per event (reset value 0). This block synchronizes that level
// into the clk domain and deglitches it. Every accepted level change becomes
// a one-cycle event pulse. Events are held as a pending count, drained through
// a valid/ready handshake, and tallied in a wrapping running counter.
//
// Ports:
//   clk        in   single clock, rising edge
//   reset      in   asynchronous active-high reset, clears all state
//   t_in       in   toggle-encoded level from the sender (asynchronous)
//   en         in   detection enable; changes seen while low are discarded
//   evt_pulse  out  one-cycle pulse per detected, enabled toggle
//   evt_valid  out  high while pending != 0
//   evt_ready  in   consumer accepts one event when evt_valid & evt_ready
//   pending    out  [PEND_W] events detected but not yet accepted
//   evt_count  out  [CNT_W] total detected, enabled toggles (wraps)
//   overflow   out  sticky flag: an event was lost because pending was full
//   clr_ovf    in   synchronous clear of overflow (a same-cycle set wins)
//   level_q    out  filtered, accepted level of t_in
//
// Handshake: evt_valid is a combinational decode of the pending register.
// One event is consumed on every rising edge where evt_valid and evt_ready
// are both high. evt_ready has no effect while evt_valid is low. valid never
// depends on ready, so the consumer may tie ready high or derive it from
// valid.
//
// Parameters: SYNC_STAGES 2..4, FILTER_CYCLES 1..15, CNT_W, PEND_W.
// ---------------------------------------------------------------------------
module toggle_event_receiver #(
   parameter int SYNC_STAGES   = 2,
   parameter int FILTER_CYCLES = 2,
   parameter int CNT_W         = 8,
   parameter int PEND_W        = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              t_in,
   input  logic              en,
   output logic              evt_pulse,
   output logic              evt_valid,
   input  logic              evt_ready,
   output logic [PEND_W-1:0] pending,
   output logic [CNT_W-1:0]  evt_count,
   output logic              overflow,
   input  logic              clr_ovf,
   output logic              level_q
);

   // The filter counter only needs to reach FILTER_CYCLES-1 (at most 14).
   localparam logic [3:0]        FILT_LAST = 4'(FILTER_CYCLES - 1);
   localparam logic [3:0]        FILT_ONE  = 4'd1;
   localparam logic [PEND_W-1:0] PEND_FULL = '1;
   localparam logic [PEND_W-1:0] PEND_ONE  = PEND_W'(1);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s;
   logic [3:0]             filt_cnt;
   logic                   flip;
   logic                   inc;
   logic                   dec;
   logic                   full;
   logic                   ovf_set;

   // ------------------------------------------------------------------
   // Synchronizer. The chain resets to 0, which matches the sender's reset
   // level, so a 1 seen after reset is a genuine toggle.
   // ------------------------------------------------------------------
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], t_in};
      end
   end

   assign s = sync_q[SYNC_STAGES-1];

   // ------------------------------------------------------------------
   // Deglitch filter. filt_cnt counts consecutive samples in which s has
   // differed from the accepted level. The level flips on the edge where
   // that run would reach FILTER_CYCLES. Any sample that agrees with the
   // accepted level restarts the run, so short excursions leave no trace.
   // ------------------------------------------------------------------
   assign flip = (s != level_q) && (filt_cnt == FILT_LAST);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         level_q  <= 1'b0;
         filt_cnt <= '0;
      end else if (s == level_q) begin
         filt_cnt <= '0;
      end else if (flip) begin
         level_q  <= s;
         filt_cnt <= '0;
      end else begin
         filt_cnt <= filt_cnt + FILT_ONE;
      end
   end

   // ------------------------------------------------------------------
   // Event bookkeeping. Every flip of the accepted level is an event, in
   // either direction. While en is low, the level still tracks t_in, but
   // the event is dropped for good.
   // ------------------------------------------------------------------
   assign evt_valid = (pending != '0);
   assign inc       = flip & en;
   assign dec       = evt_valid & evt_ready;
   assign full      = (pending == PEND_FULL);
   // When an event is accepted in the same cycle, that frees the slot.
   // A full queue therefore only loses an event when nothing drains.
   assign ovf_set   = inc & ~dec & full;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pending <= '0;
      end else begin
         case ({inc, dec})
            2'b10:   if (!full) pending <= pending + PEND_ONE;
            2'b01:   pending <= pending - PEND_ONE;
            default: pending <= pending;
         endcase
      end
   end

   // The pulse and the running count fire even for an event that the
   // pending queue had to drop.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         evt_pulse <= 1'b0;
         evt_count <= '0;
      end else begin
         evt_pulse <= inc;
         if (inc) begin
            evt_count <= evt_count + CNT_ONE;
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         overflow <= 1'b0;
      end else if (ovf_set) begin
         overflow <= 1'b1;
      end else if (clr_ovf) begin
         overflow <= 1'b0;
      end
   end

endmodule

// File: doc/toggle_event_receiver.md
Name: toggle_event_receiver

Overview:
- Receiving end of the toggle-encoded event interface. The sender is a T-type storage element with reset-to-0 that flips its output once per event.
- The block synchronizes and deglitches the toggle level and converts every level change back into a one-cycle event pulse.
- Events are queued as a pending count, drained through a valid/ready handshake, and tallied in a running counter.
- Sits between any toggle-signalling producer and the consuming control logic in the `clk` domain.

Parameters:
- SYNC_STAGES, 2, synchronizer flops on `t_in`; legal range 2..4.
- FILTER_CYCLES, 2, consecutive synchronized samples a new level must hold before it is accepted; 1 disables filtering; legal range 1..15.
- CNT_W, 8, width of the running event counter.
- PEND_W, 4, width of the pending-event counter; capacity is 2^PEND_W-1 events.

Ports:
- `clk` in 1: single clock; all state updates on the rising edge.
- `reset` in 1: asynchronous, active-high; clears all state immediately.
- `t_in` in 1: toggle-encoded level from the remote sender; asynchronous to `clk`.
- `en` in 1: detection enable.
- `evt_pulse` out 1: one-cycle pulse per detected, enabled toggle.
- `evt_valid` out 1: high while pending is nonzero.
- `evt_ready` in 1: consumer accepts one event when `evt_valid` and `evt_ready` are both high.
- `pending` out PEND_W: events detected but not yet accepted.
- `evt_count` out CNT_W: total detected, enabled toggles; wraps modulo 2^CNT_W.
- `overflow` out 1: sticky; set when an event is lost.
- `clr_ovf` in 1: synchronous clear of `overflow`.
- `level_q` out 1: filtered, accepted level of `t_in`.

Behaviour:
- Reset (async assert, sync to `clk` on release): synchronizer chain, `level_q`, filter counter, `pending`, `evt_count`, `overflow` and `evt_pulse` all go to 0.
  - The reset value 0 matches the sender's reset value, so a 1 seen after reset is a genuine toggle.
- Synchronizer: `t_in` passes through SYNC_STAGES flops; `s` denotes the last stage.
- Filter:
  - When `s` != `level_q`, the stability counter increments each cycle; when `s` == `level_q`, it clears to 0.
  - When the counter would reach FILTER_CYCLES, `level_q` <= `s` and the counter clears.
  - An excursion shorter than FILTER_CYCLES synchronized samples is rejected entirely: no level change, no event.
- Detect: an event occurs on the edge where `level_q` changes, in either direction.
- Latency: with `t_in` stable and meeting setup before edge E0, `level_q` flips and `evt_pulse`, `pending` and `evt_count` update at edge E0+SYNC_STAGES+FILTER_CYCLES-1. With defaults, `evt_pulse` is high in the 4th cycle after E0.
- `en`=0:
  - `level_q` still tracks `t_in`, but detected changes are discarded.
  - No pulse, no count, no pending change.
  - Toggles made while disabled are never replayed.
- Pending update per cycle:
  - Let inc = event & `en`, and dec = `evt_valid` & `evt_ready`.
  - inc only: +1. dec only: -1. Both: unchanged, and the event is counted.
  - `evt_valid` = (`pending` != 0), combinational from the register. It rises in the same cycle as the first `evt_pulse`.
  - `evt_ready` while `evt_valid`=0 has no effect.
- Full boundary:
  - If `pending` = 2^PEND_W-1 and inc with no dec: `pending` holds, `overflow` <= 1, the event is lost from the queue.
  - `evt_pulse` and `evt_count` still fire for the lost event.
- `overflow`:
  - Cleared by `clr_ovf`.
  - If a set condition and `clr_ovf` occur in the same cycle, set wins.
- `evt_count` wraps from 2^CNT_W-1 to 0 with no flag.
- Reset mid-operation discards all pending events and any partially filtered level.

Test Plan:
- Reset, then `t_in` 0->1 at edge E0 with `en`=1, defaults, `evt_ready`=0 -> `evt_pulse` is a single cycle at E0+3. Then `pending`=1, `evt_valid`=1, `evt_count`=1, `level_q`=1.
- Drive 3 toggles spaced 8 cycles apart with `evt_ready`=0, then hold `evt_ready`=1 -> `pending` reaches 3, then drains 3->2->1->0 on consecutive edges; `evt_valid` drops the cycle `pending` hits 0.
- 1-cycle high glitch on `t_in` with FILTER_CYCLES=2 -> `level_q` stays 0, no `evt_pulse`, `evt_count`=0.
- PEND_W=2: 4 toggles with `evt_ready`=0 -> `pending` saturates at 3, `overflow`=1, `evt_count`=4. Assert `clr_ovf` together with a 5th toggle -> `overflow` stays 1. Assert `clr_ovf` alone next -> `overflow`=0.
- Event detected in the same cycle as `evt_valid`&`evt_ready` with `pending`=2 -> `pending` stays 2, `evt_count` increments by 1.
- `en`=0 during 2 toggles, then `en`=1 -> no pulses and `evt_count` unchanged, while `level_q` follows `t_in`. Assert `reset` with `pending`=3 -> all outputs 0 immediately, without waiting for a clock edge.
